// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory image loader.
//   imem_ld_state_e   loader FSM states
//   IMEM_ERR_*        err_code values reported on load_err
//   IMEM_NUM_INST_DEF default instruction memory depth in bytes
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } imem_ld_state_e;

   localparam logic [1:0] IMEM_ERR_NONE = 2'd0;
   localparam logic [1:0] IMEM_ERR_ZERO = 2'd1;
   localparam logic [1:0] IMEM_ERR_LEN  = 2'd2;
   localparam logic [1:0] IMEM_ERR_CSUM = 2'd3;

   localparam int unsigned IMEM_NUM_INST_DEF = 256;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the loader's byte-stream input, instruction-memory
// write port and status outputs.
//   in_valid/in_data/in_ready    byte stream (transfer on valid && ready)
//   start                        re-arm pulse from DONE or ERR
//   mem_we/mem_addr/mem_wdata    byte write port into instruction memory
//   cpu_hold/load_done/load_err/err_code  status to the core
// Modports: slave = loader side, master = source/observer side.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 8
) ();

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              start;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [1:0]        err_code;

   modport slave (
      input  in_valid, in_data, start,
      output in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_err, err_code
   );

   modport master (
      output in_valid, in_data, start,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_err, err_code
   );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed program image over
// a valid/ready byte stream and writes it little-endian into the instruction
// memory's byte write port. The core is held in reset until a full image
// with a matching checksum has landed.
// Ports:
//   clk    single clock
//   reset  synchronous, active-high
//   bus    imem_loader_if slave (byte stream, memory write port, status)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned NUM_INST = IMEM_NUM_INST_DEF,
   parameter int unsigned ADDR_W   = $clog2(NUM_INST)
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  bus
);

   imem_ld_state_e    state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [17:0]       cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [1:0]        code_q, code_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;

   logic              ready;
   logic              accept;
   logic [17:0]       total_bytes;

   // Readiness is decoded from state only; reset forces it low so nothing
   // is taken while the block is being cleared.
   assign ready = !reset && (state_q == LEN0 || state_q == LEN1 ||
                             state_q == DATA || state_q == CSUM);
   assign accept      = ready && bus.in_valid;
   assign total_bytes = {len_q, 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LEN0;
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         code_q  <= IMEM_ERR_NONE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         code_q  <= code_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      code_d  = code_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         LEN0: begin
            if (accept) begin
               len_d   = {8'h00, bus.in_data};
               state_d = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               len_d = {bus.in_data, len_q[7:0]};
               if (len_d == 16'd0) begin
                  state_d = ERR;
                  code_d  = IMEM_ERR_ZERO;
               end else if ({len_d, 2'b00} > 18'(NUM_INST)) begin
                  state_d = ERR;
                  code_d  = IMEM_ERR_LEN;
               end else begin
                  cnt_d   = '0;
                  csum_d  = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = bus.in_data;
               cnt_d   = cnt_q + 18'd1;
               csum_d  = csum_q ^ bus.in_data;
               if (cnt_q == total_bytes - 18'd1) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d = ERR;
                  code_d  = IMEM_ERR_CSUM;
               end
            end
         end
         DONE, ERR: begin
            if (bus.start) begin
               state_d = LEN0;
               code_d  = IMEM_ERR_NONE;
            end
         end
         default: begin
            state_d = LEN0;
         end
      endcase
   end

   // Status outputs decode the state register, so they change the cycle
   // after the final accepted byte.
   assign bus.in_ready  = ready;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_hold  = (state_q != DONE);
   assign bus.load_done = (state_q == DONE);
   assign bus.load_err  = (state_q == ERR);
   assign bus.err_code  = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Accepted payload bytes
// push the expected write (address, data, cycle) into a queue; a monitor on
// the falling edge pops and compares every mem_we it sees. Status outputs
// are checked directly by the stimulus process.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_loader_if #(.ADDR_W(8)) ifc ();

   imem_loader #(.NUM_INST(256), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] tb_mem[256];
   logic [7:0] frame[16];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fetch(input int pc);
      return {tb_mem[pc+3], tb_mem[pc+2], tb_mem[pc+1], tb_mem[pc]};
   endfunction

   // Monitor: every write must match the oldest expected write, including
   // the exact cycle (one after acceptance).
   always @(negedge clk) begin
      if (ifc.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {16'h0, ifc.mem_addr, ifc.mem_wdata}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr",  32'(ifc.mem_addr),  32'(e.addr));
            check("wr_data",  32'(ifc.mem_wdata), 32'(e.data));
            check("wr_cycle", 32'(cyc),           32'(e.cyc));
         end
         tb_mem[ifc.mem_addr] = ifc.mem_wdata;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'hxx;
   endtask

   // Present one byte and hold it until accepted (bounded wait).
   task automatic send_byte(input logic [7:0] b, input bit is_pay, input logic [7:0] addr,
                            input int gap);
      bit rdy;
      int c;
      bit done;
      done = 1'b0;
      ifc.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = b;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         rdy = ifc.in_ready;
         c   = cyc;
         @(posedge clk);
         if (rdy) begin
            done = 1'b1;
            if (is_pay) exp_q.push_back('{addr: addr, data: b, cyc: c + 1});
         end
      end
      #1;
      ifc.in_valid = 1'b0;
      if (!done) check("accept_timeout", 32'd0, 32'd1);
   endtask

   // Send frame[0..nbytes-1]; bytes 2..2+npay-1 are payload.
   task automatic send_frame(input int nbytes, input int npay, input bit gaps);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(frame[i], (i >= 2 && i < 2 + npay), 8'(i - 2),
                   gaps ? int'($urandom_range(0, 2)) : 0);
      end
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
   endtask

   task automatic load_program_frame();
      frame[0] = 8'h02; frame[1] = 8'h00;
      frame[2] = 8'h33; frame[3] = 8'h00; frame[4] = 8'h00; frame[5] = 8'h00;
      frame[6] = 8'h33; frame[7] = 8'h00; frame[8] = 8'h00; frame[9] = 8'h40;
      frame[10] = 8'h40;
   endtask

   task automatic check_program_done(input string tag);
      @(negedge clk);
      check({tag, "_done"},     32'(ifc.load_done), 32'd1);
      check({tag, "_err"},      32'(ifc.load_err),  32'd0);
      check({tag, "_hold"},     32'(ifc.cpu_hold),  32'd0);
      check({tag, "_ready"},    32'(ifc.in_ready),  32'd0);
      check({tag, "_code"},     32'(ifc.err_code),  32'd0);
      check({tag, "_fetch0"},   fetch(0),           32'h0000_0033);
      check({tag, "_fetch4"},   fetch(4),           32'h4000_0033);
      check({tag, "_pending"},  32'(exp_q.size()),  32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'h00;
      ifc.start    = 1'b0;
      clear_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ifc.in_ready),  32'd0);
      check("rst_we",    32'(ifc.mem_we),    32'd0);
      check("rst_addr",  32'(ifc.mem_addr),  32'd0);
      check("rst_wdata", 32'(ifc.mem_wdata), 32'd0);
      check("rst_hold",  32'(ifc.cpu_hold),  32'd1);
      check("rst_done",  32'(ifc.load_done), 32'd0);
      check("rst_err",   32'(ifc.load_err),  32'd0);
      check("rst_code",  32'(ifc.err_code),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(ifc.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Program load, back-to-back bytes
      load_program_frame();
      send_frame(11, 8, 1'b0);
      check_program_done("load");

      // Same frame with random idle gaps
      pulse_start();
      clear_mem();
      @(negedge clk);
      check("rearm_done",  32'(ifc.load_done), 32'd0);
      check("rearm_hold",  32'(ifc.cpu_hold),  32'd1);
      check("rearm_ready", 32'(ifc.in_ready),  32'd1);
      @(posedge clk);
      #1;
      send_frame(11, 8, 1'b1);
      check_program_done("gaps");

      // Zero length
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h00;
      send_frame(2, 0, 1'b0);
      @(negedge clk);
      check("zero_err",   32'(ifc.load_err), 32'd1);
      check("zero_code",  32'(ifc.err_code), 32'd1);
      check("zero_ready", 32'(ifc.in_ready), 32'd0);
      check("zero_hold",  32'(ifc.cpu_hold), 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // Oversize: 65 words > 256 bytes
      pulse_start();
      frame[0] = 8'h41; frame[1] = 8'h00;
      send_frame(2, 0, 1'b0);
      @(negedge clk);
      check("big_err",   32'(ifc.load_err), 32'd1);
      check("big_code",  32'(ifc.err_code), 32'd2);
      check("big_ready", 32'(ifc.in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // Checksum mismatch: 11^22^33^44 = 44, send 45
      pulse_start();
      clear_mem();
      frame[0] = 8'h01; frame[1] = 8'h00;
      frame[2] = 8'h11; frame[3] = 8'h22; frame[4] = 8'h33; frame[5] = 8'h44;
      frame[6] = 8'h45;
      send_frame(7, 4, 1'b0);
      @(negedge clk);
      check("csum_err",    32'(ifc.load_err), 32'd1);
      check("csum_code",   32'(ifc.err_code), 32'd3);
      check("csum_hold",   32'(ifc.cpu_hold), 32'd1);
      check("csum_fetch0", fetch(0),          32'h4433_2211);
      @(posedge clk);
      #1;
      pulse_start();
      @(negedge clk);
      check("csum_clr_code", 32'(ifc.err_code), 32'd0);
      check("csum_clr_err",  32'(ifc.load_err), 32'd0);
      @(posedge clk);
      #1;
      load_program_frame();
      send_frame(11, 8, 1'b0);
      check_program_done("reload");

      // Reset after 3 of 8 payload bytes
      pulse_start();
      clear_mem();
      load_program_frame();
      send_frame(5, 3, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_we",    32'(ifc.mem_we),    32'd0);
      check("midrst_ready", 32'(ifc.in_ready),  32'd0);
      check("midrst_hold",  32'(ifc.cpu_hold),  32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_len0_ready", 32'(ifc.in_ready),  32'd1);
      check("midrst_done",       32'(ifc.load_done), 32'd0);
      @(posedge clk);
      #1;
      send_frame(11, 8, 1'b0);
      check_program_done("after_rst");

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
